// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined ARM shifter-operand unit.
// This package holds the IR field positions, the shift-type codes and the decoded-op record.
package shifter_pkg;

    localparam int MAX_W = 64;

    localparam int I_BIT     = 25;
    localparam int REGSH_BIT = 4;
    localparam int TYPE_HI   = 6;
    localparam int TYPE_LO   = 5;
    localparam int IMM5_HI   = 11;
    localparam int IMM5_LO   = 7;
    localparam int ROT_HI    = 11;
    localparam int ROT_LO    = 8;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    // value is sized for the widest datapath; narrower units use the low WIDTH bits
    typedef struct packed {
        logic [MAX_W-1:0] value;
        logic [8:0]       amt;
        shift_t           typ;
        logic             rrx;
        logic             c;
    } dec_op_t;

endpackage

// File: rtl/shifter_core.sv
// Combinational shift stage: decoded op -> shifter operand and carry-out.
// The amount is already normalised, so "0" always means pass-through with the incoming C.
module shifter_core
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  dec_op_t          op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    localparam int         LOG_W = $clog2(WIDTH);
    localparam logic [8:0] W9    = 9'(WIDTH);

    logic [WIDTH-1:0]   v;
    logic [MAX_W-1:0]   unused_value;
    logic [8:0]         amt_sat;
    logic [LOG_W-1:0]   rot;
    logic [WIDTH:0]     lsl_w;
    logic [WIDTH:0]     lsr_w;
    logic [WIDTH:0]     asr_w;
    logic [2*WIDTH-1:0] ror_w;

    assign v            = op.value[WIDTH-1:0];
    assign unused_value = op.value;
    assign amt_sat      = (op.amt > W9) ? W9 : op.amt;
    assign rot          = op.amt[LOG_W-1:0];

    // one extra bit on the outgoing side catches the last bit shifted out
    assign lsl_w = {1'b0, v} << amt_sat;
    assign lsr_w = {v, 1'b0} >> amt_sat;
    assign asr_w = $signed({v, 1'b0}) >>> amt_sat;
    assign ror_w = {v, v} >> rot;

    always_comb begin
        result = v;
        carry  = op.c;
        if (op.rrx) begin
            result = {op.c, v[WIDTH-1:1]};
            carry  = v[0];
        end else if (op.amt != 9'd0) begin
            case (op.typ)
                SH_LSL: begin
                    if (op.amt > W9) begin
                        result = '0;
                        carry  = 1'b0;
                    end else begin
                        result = lsl_w[WIDTH-1:0];
                        carry  = lsl_w[WIDTH];
                    end
                end
                SH_LSR: begin
                    if (op.amt > W9) begin
                        result = '0;
                        carry  = 1'b0;
                    end else begin
                        result = lsr_w[WIDTH:1];
                        carry  = lsr_w[0];
                    end
                end
                SH_ASR: begin
                    result = asr_w[WIDTH:1];
                    carry  = asr_w[0];
                end
                // a rotate by a multiple of WIDTH leaves v, so result[W-1] is also the right carry
                SH_ROR: begin
                    result = ror_w[WIDTH-1:0];
                    carry  = ror_w[WIDTH-1];
                end
                default: begin
                    result = v;
                    carry  = op.c;
                end
            endcase
        end
    end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Two-stage elastic shifter-operand unit: stage 1 registers the decoded op, stage 2 the shift result.
// The ready chain lets a bubble in either stage absorb a new op even while the output is stalled.
module barrel_shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_ir,
    input  logic [WIDTH-1:0] in_rs,
    input  logic [WIDTH-1:0] in_rm,
    input  logic             in_c,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_c,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [8:0] W9 = 9'(WIDTH);

    dec_op_t          dec;
    logic [4:0]       n5;
    logic [4:0]       rot2;
    logic             s1_v;
    dec_op_t          s1_op;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_v;
    logic [WIDTH-1:0] s2_result;
    logic             s2_c;
    logic [TAG_W-1:0] s2_tag;
    logic             s1_en;
    logic             s2_en;
    logic [WIDTH-1:0] core_result;
    logic             core_c;
    logic [WIDTH-9+18:0] unused_bits;

    assign unused_bits = {in_ir[31:26], in_ir[24:12], in_rs[WIDTH-1:8]};

    assign s2_en    = !s2_v || out_ready;
    assign s1_en    = !s1_v || s2_en;
    assign in_ready = s1_en && !flush && !reset;

    assign n5   = in_ir[IMM5_HI:IMM5_LO];
    assign rot2 = {in_ir[ROT_HI:ROT_LO], 1'b0};

    always_comb begin
        dec     = '0;
        dec.c   = in_c;
        dec.typ = shift_t'(in_ir[TYPE_HI:TYPE_LO]);
        if (in_ir[I_BIT]) begin
            dec.value = MAX_W'(in_ir[7:0]);
            dec.typ   = SH_ROR;
            dec.amt   = 9'(rot2) & (W9 - 9'd1);
        end else begin
            dec.value = MAX_W'(in_rm);
            if (in_ir[REGSH_BIT]) begin
                dec.amt = {1'b0, in_rs[7:0]};
            end else if (n5 != 5'd0) begin
                dec.amt = 9'(n5);
            end else begin
                // a zero immediate amount encodes LSR/ASR #W and RRX
                case (dec.typ)
                    SH_LSR, SH_ASR: dec.amt = W9;
                    SH_ROR:         dec.rrx = 1'b1;
                    default:        dec.amt = 9'd0;
                endcase
            end
        end
    end

    shifter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .op    (s1_op),
        .result(core_result),
        .carry (core_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v      <= 1'b0;
            s1_op     <= '0;
            s1_tag    <= '0;
            s2_v      <= 1'b0;
            s2_result <= '0;
            s2_c      <= 1'b0;
            s2_tag    <= '0;
        end else if (flush) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_v <= in_valid;
                if (in_valid) begin
                    s1_op  <= dec;
                    s1_tag <= in_tag;
                end
            end
            if (s2_en) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_result <= core_result;
                    s2_c      <= core_c;
                    s2_tag    <= s1_tag;
                end
            end
        end
    end

    assign out_valid  = s2_v;
    assign out_result = s2_result;
    assign out_c      = s2_c;
    assign out_tag    = s2_tag;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe: expected results are queued on accept
// and popped by an independent monitor whenever the unit hands a result over.
module tb_barrel_shifter_pipe;

    localparam int W  = 32;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_ir;
    logic [W-1:0]  in_rs;
    logic [W-1:0]  in_rm;
    logic          in_c;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_c;
    logic [TW-1:0] out_tag;

    typedef struct {
        logic [TW-1:0] tag;
        logic [W-1:0]  res;
        logic          c;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          e;
    logic [W:0]    cur_exp;
    int            total = 0;
    int            bad = 0;
    bit            acc_s = 0;
    bit            kill_s = 0;
    bit            last_acc = 0;
    bit            hold_chk = 0;
    logic [W-1:0]  h_res;
    logic          h_c;
    logic [TW-1:0] h_tag;
    logic [TW-1:0] seq_tag = '0;

    barrel_shifter_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ir     (in_ir),
        .in_rs     (in_rs),
        .in_rm     (in_rm),
        .in_c      (in_c),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_c     (out_c),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int r);
        logic [31:0] y;
        y = x;
        for (int i = 0; i < r; i++) y = {y[0], y[31:1]};
        return y;
    endfunction

    // reference: {carry, result} from the architectural rules, one case at a time
    function automatic logic [32:0] model(input logic [31:0] ir, input logic [31:0] rs,
                                          input logic [31:0] rm, input logic c);
        logic [31:0] res;
        logic        co;
        int          n;
        int          t;
        if (ir[25]) begin
            n   = 2 * int'(ir[11:8]);
            res = rotr({24'd0, ir[7:0]}, n);
            co  = (n == 0) ? c : res[31];
            return {co, res};
        end
        t = int'(ir[6:5]);
        if (ir[4]) begin
            n = int'(rs[7:0]);
            if (n == 0) return {c, rm};
        end else begin
            n = int'(ir[11:7]);
            if (n == 0) begin
                if (t == 0) return {c, rm};
                if (t == 3) return {rm[0], c, rm[31:1]};
                n = 32;
            end
        end
        case (t)
            0: begin
                if (n > 32) begin res = 0; co = 0; end
                else if (n == 32) begin res = 0; co = rm[0]; end
                else begin res = rm << n; co = rm[32 - n]; end
            end
            1: begin
                if (n > 32) begin res = 0; co = 0; end
                else if (n == 32) begin res = 0; co = rm[31]; end
                else begin res = rm >> n; co = rm[n - 1]; end
            end
            2: begin
                if (n >= 32) begin res = {32{rm[31]}}; co = rm[31]; end
                else begin res = 32'($signed(rm) >>> n); co = rm[n - 1]; end
            end
            default: begin
                res = rotr(rm, n % 32);
                co  = res[31];
            end
        endcase
        return {co, res};
    endfunction

    function automatic logic [31:0] ir_imm(input int rot, input int imm);
        return 32'((1 << 25) | (rot << 8) | imm);
    endfunction

    function automatic logic [31:0] ir_reg(input int t);
        return 32'((t << 5) | (1 << 4));
    endfunction

    function automatic logic [31:0] ir_ish(input int n, input int t);
        return 32'((n << 7) | (t << 5));
    endfunction

    // monitor / scoreboard; runs just before each rising edge
    always begin
        @(negedge clk);
        #4;
        if (hold_chk) begin
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_result", 64'(out_result), 64'(h_res));
            chk("hold_c", 64'(out_c), 64'(h_c));
            chk("hold_tag", 64'(out_tag), 64'(h_tag));
        end
        hold_chk = (out_valid === 1'b1) && !out_ready && !flush && !reset;
        h_res = out_result;
        h_c   = out_c;
        h_tag = out_tag;
        if (out_valid === 1'b1 && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got tag 0x%0h result 0x%0h, want no output", out_tag, out_result);
            end else begin
                e = exp_q.pop_front();
                chk("out_tag", 64'(out_tag), 64'(e.tag));
                chk("out_result", 64'(out_result), 64'(e.res));
                chk("out_c", 64'(out_c), 64'(e.c));
            end
        end
        acc_s  = (in_valid === 1'b1) && (in_ready === 1'b1);
        kill_s = flush || reset;
        if (acc_s) exp_q.push_back('{in_tag, cur_exp[W-1:0], cur_exp[W]});
        if (kill_s) exp_q.delete();
    end

    task automatic tick();
        @(posedge clk);
        #1;
        last_acc = acc_s;
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] ir, input logic [W-1:0] rs, input logic [W-1:0] rm,
                        input logic c, input logic [TW-1:0] tag, input logic [W:0] exp);
        in_ir = ir; in_rs = rs; in_rm = rm; in_c = c; in_tag = tag; cur_exp = exp;
        in_valid = 1'b1;
        last_acc = 0;
        for (int k = 0; k < 64; k++) begin
            tick();
            if (last_acc) break;
        end
        if (!last_acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no accept for tag 0x%0h, want accept", tag);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_d(input logic [31:0] ir, input logic [W-1:0] rs, input logic [W-1:0] rm,
                          input logic c, input logic [W:0] exp);
        send(ir, rs, rm, c, seq_tag, exp);
        seq_tag = seq_tag + 1'b1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
        tick();
        chk("drain_pending", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_ir = '0; in_rs = '0; in_rm = '0; in_c = 1'b0; in_tag = '0; cur_exp = '0;
        @(negedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'(0));
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_out_result", 64'(out_result), 64'(0));
        chk("reset_out_c", 64'(out_c), 64'(0));
        chk("reset_out_tag", 64'(out_tag), 64'(0));
        tick();
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 64'(in_ready), 64'(1));

        // immediates, register shifts, immediate-shift encodings and amount boundaries
        send_d(ir_imm(8, 'h01), 0, 0, 1'b0, {1'b0, 32'h0001_0000});
        send_d(ir_imm(0, 'hFF), 0, 0, 1'b1, {1'b1, 32'h0000_00FF});
        send_d(ir_reg(0), 8, 32'h1, 1'b0, {1'b0, 32'h0000_0100});
        send_d(ir_reg(1), 32, 32'h8000_0000, 1'b0, {1'b1, 32'h0});
        send_d(ir_reg(2), 40, 32'hF000_0001, 1'b0, {1'b1, 32'hFFFF_FFFF});
        send_d(ir_reg(3), 8, 32'hF000_0001, 1'b1, {1'b0, 32'h01F0_0000});
        send_d(ir_ish(0, 3), 0, 32'h3, 1'b1, {1'b1, 32'h8000_0001});
        send_d(ir_ish(0, 1), 0, 32'h8000_0000, 1'b0, {1'b1, 32'h0});
        send_d(ir_ish(0, 0), 0, 32'h1234_5678, 1'b1, {1'b1, 32'h1234_5678});
        for (int t = 0; t < 4; t++)
            send_d(ir_reg(t), 32'hABCD_0100, 32'hA5A5_A5A5, 1'(t & 1), {1'(t & 1), 32'hA5A5_A5A5});
        send_d(ir_reg(0), 32, 32'h1, 1'b0, {1'b1, 32'h0});
        send_d(ir_reg(0), 33, 32'hFFFF_FFFF, 1'b1, {1'b0, 32'h0});
        send_d(ir_reg(1), 33, 32'hFFFF_FFFF, 1'b1, {1'b0, 32'h0});
        send_d(ir_reg(3), 32, 32'h8000_0000, 1'b0, {1'b1, 32'h8000_0000});
        send_d(ir_reg(3), 36, 32'h0000_0010, 1'b1, {1'b0, 32'h0000_0001});
        send_d(ir_ish(0, 2), 0, 32'h8000_0000, 1'b0, {1'b1, 32'hFFFF_FFFF});
        send_d(ir_ish(1, 0), 0, 32'h8000_0001, 1'b0, {1'b1, 32'h0000_0002});
        send_d(ir_ish(31, 1), 0, 32'h4000_0000, 1'b0, {1'b1, 32'h0});
        drain();

        // backpressure: two accepts fill the pipe, then in_ready must drop
        out_ready = 1'b0;
        send(ir_reg(0), 4, 32'h11, 1'b0, 4'd0, model(ir_reg(0), 4, 32'h11, 1'b0));
        send(ir_reg(1), 4, 32'h22, 1'b0, 4'd1, model(ir_reg(1), 4, 32'h22, 1'b0));
        in_ir = ir_reg(2); in_rs = 4; in_rm = 32'h8000_0033; in_c = 1'b0; in_tag = 4'd2;
        cur_exp = model(in_ir, in_rs, in_rm, in_c);
        in_valid = 1'b1;
        #1;
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        tick();
        out_ready = 1'b1;
        send(ir_reg(2), 4, 32'h8000_0033, 1'b0, 4'd2, model(ir_reg(2), 4, 32'h8000_0033, 1'b0));
        send(ir_reg(3), 4, 32'h44, 1'b0, 4'd3, model(ir_reg(3), 4, 32'h44, 1'b0));
        drain();

        // flush with two ops in flight; the op offered alongside must be refused
        out_ready = 1'b0;
        send(ir_reg(0), 1, 32'h5, 1'b0, 4'd5, model(ir_reg(0), 1, 32'h5, 1'b0));
        send(ir_reg(0), 2, 32'h6, 1'b0, 4'd6, model(ir_reg(0), 2, 32'h6, 1'b0));
        flush = 1'b1;
        in_ir = ir_reg(0); in_rs = 3; in_rm = 32'h7; in_c = 1'b0; in_tag = 4'd7;
        cur_exp = model(in_ir, in_rs, in_rm, in_c);
        in_valid = 1'b1;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'(0));
        tick();
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk("flush_no_accept", 64'(out_valid), 64'(0));

        // reset in the middle of traffic
        out_ready = 1'b0;
        send(ir_imm(4, 'h3C), 0, 0, 1'b1, 4'd9, model(ir_imm(4, 'h3C), 0, 0, 1'b1));
        send(ir_reg(2), 1, 32'hFFFF_FFFE, 1'b0, 4'd10, model(ir_reg(2), 1, 32'hFFFF_FFFE, 1'b0));
        reset = 1'b1;
        #1;
        chk("midreset_in_ready", 64'(in_ready), 64'(0));
        tick();
        chk("midreset_out_valid", 64'(out_valid), 64'(0));
        chk("midreset_out_result", 64'(out_result), 64'(0));
        chk("midreset_out_c", 64'(out_c), 64'(0));
        chk("midreset_out_tag", 64'(out_tag), 64'(0));
        reset = 1'b0;
        out_ready = 1'b1;
        tick();

        // random traffic with random backpressure
        for (int i = 0; i < 500; i++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            in_valid  = ($urandom_range(0, 9) < 8);
            in_ir     = $urandom;
            in_rs     = $urandom;
            if ($urandom_range(0, 1) == 0) in_rs[7:0] = 8'($urandom_range(0, 40));
            in_rm     = $urandom;
            in_c      = 1'($urandom_range(0, 1));
            in_tag    = 4'($urandom_range(0, 15));
            cur_exp   = model(in_ir, in_rs, in_rm, in_c);
            tick();
        end
        in_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
